// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with memory wait timeout and a sticky trap.
// Optional halfword loads/stores (lh/sh) are enabled by defining MULTICYCLE_HALFWORD_EN.
module multicycle_controller #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               Jal,
    output logic               Jr,
    output logic               Signextend,
    output logic               Branch,
    output logic               Bne,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JREG, C_ILLEGAL
    } cls_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       hold_q;
    logic [5:0] opcode_q, funct_q;

    cls_e       cls;
    logic [3:0] cls_alu;
    logic       cls_half, cls_link, cls_bne;
    logic [3:0] alu_op_c;
    logic       wait_last;

    // Holding the instruction fields locally keeps every later phase Moore on registered state.
    always_comb begin
        cls      = C_ILLEGAL;
        cls_alu  = 4'd0;
        cls_half = 1'b0;
        cls_link = 1'b0;
        cls_bne  = 1'b0;
        case (opcode_q)
            6'h00: begin
                case (funct_q)
                    6'h20: begin cls = C_ALU_R; cls_alu = 4'd0; end
                    6'h22: begin cls = C_ALU_R; cls_alu = 4'd1; end
                    6'h24: begin cls = C_ALU_R; cls_alu = 4'd2; end
                    6'h25: begin cls = C_ALU_R; cls_alu = 4'd3; end
                    6'h26: begin cls = C_ALU_R; cls_alu = 4'd4; end
                    6'h27: begin cls = C_ALU_R; cls_alu = 4'd5; end
                    6'h2A: begin cls = C_ALU_R; cls_alu = 4'd6; end
                    6'h00: begin cls = C_ALU_R; cls_alu = 4'd7; end
                    6'h02: begin cls = C_ALU_R; cls_alu = 4'd8; end
                    6'h08: cls = C_JREG;
                    6'h09: begin cls = C_JREG; cls_link = 1'b1; end
                    default: cls = C_ILLEGAL;
                endcase
            end
            6'h08: begin cls = C_ALU_I; cls_alu = 4'd0; end
            6'h0C: begin cls = C_ALU_I; cls_alu = 4'd2; end
            6'h0A: begin cls = C_ALU_I; cls_alu = 4'd6; end
            6'h0D: begin cls = C_ALU_I; cls_alu = 4'd3; end
            6'h23: cls = C_LOAD;
            6'h2B: cls = C_STORE;
`ifdef MULTICYCLE_HALFWORD_EN
            6'h21: begin cls = C_LOAD;  cls_half = 1'b1; end
            6'h29: begin cls = C_STORE; cls_half = 1'b1; end
`endif
            6'h04: begin cls = C_BRANCH; cls_alu = 4'd9; end
            6'h05: begin cls = C_BRANCH; cls_alu = 4'd10; cls_bne = 1'b1; end
            6'h02: cls = C_JUMP;
            6'h03: begin cls = C_JUMP; cls_link = 1'b1; end
            default: cls = C_ILLEGAL;
        endcase
    end

    // True when the current waiting cycle is the MEM_TIMEOUT-th consecutive one.
    assign wait_last = ({1'b0, wait_cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        Jal        = 1'b0;
        Jr         = 1'b0;
        Signextend = 1'b0;
        Branch     = 1'b0;
        Bne        = 1'b0;
        alu_op_c   = 4'd0;
        ALUSrcB    = 2'd0;
        PCSource   = 2'd0;
        instr_done = 1'b0;
        trap       = 1'b0;
        if (hold_q) begin
            // First cycle after reset: everything quiet, FSM parked in FETCH.
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        ALUSrcB = 2'd1;
                        state_d = S_DECODE;
                    end else if (wait_last) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'd3;
                    case (cls)
                        C_JUMP: begin
                            PCWrite    = 1'b1;
                            PCSource   = 2'd2;
                            Jal        = cls_link;
                            RegWrite   = cls_link;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_JREG: begin
                            PCWrite    = 1'b1;
                            PCSource   = 2'd3;
                            Jr         = 1'b1;
                            Jal        = cls_link;
                            RegWrite   = cls_link;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        C_ILLEGAL: state_d = S_TRAP;
                        default:   state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        C_ALU_R: begin
                            alu_op_c = cls_alu;
                            state_d  = S_WB;
                        end
                        C_ALU_I: begin
                            alu_op_c = cls_alu;
                            ALUSrcB  = 2'd2;
                            state_d  = S_WB;
                        end
                        C_LOAD, C_STORE: begin
                            ALUSrcB = 2'd2;
                            state_d = S_MEM;
                        end
                        C_BRANCH: begin
                            Branch     = 1'b1;
                            alu_op_c   = cls_alu;
                            PCSource   = 2'd1;
                            Bne        = cls_bne;
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req    = 1'b1;
                    IorD       = 1'b1;
                    MemWrite   = (cls == C_STORE);
                    Signextend = cls_half;
                    if (mem_ready) begin
                        if (cls == C_STORE) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wait_last) begin
                        state_d = S_TRAP;
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = (cls == C_ALU_I) || (cls == C_LOAD);
                    MemToReg   = (cls == C_LOAD);
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_TRAP: trap = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
        if (mem_req && !mem_ready && (state_d == state_q))
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        else
            wait_cnt_d = 8'd0;
    end

    assign ALUOp = ALUOP_W'(alu_op_c);
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            hold_q     <= 1'b1;
            opcode_q   <= 6'd0;
            funct_q    <= 6'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            hold_q     <= 1'b0;
            if (IRWrite) begin
                opcode_q <= opcode;
                funct_q  <= funct;
            end
        end
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_W, default 4: ALUOp output width; SHALL be 4 or greater, with upper bits driven 0.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum mem_ready wait in cycles before trap; range 1..255.
REQ-003 Port clk  in  1: single clock; all state SHALL change on the rising edge only.
REQ-004 Port rst  in  1: reset, synchronous and active-low.
REQ-005 Port opcode  in  6, and funct  in  6: instruction fields, sampled from the IR.
REQ-006 Port mem_ready  in  1: memory completion for the current mem_req.
REQ-007 Port mem_req  out  1; MemWrite  out  1; IorD  out  1 (0 = PC address, 1 = ALU address).
REQ-008 Ports IRWrite, PCWrite, RegWrite, RegDst, MemToReg, Jal, Jr, Signextend, Branch, Bne  out  1 each.
REQ-009 Ports ALUOp  out  ALUOP_W; ALUSrcB  out  2 (0 = reg, 1 = const 4, 2 = imm, 3 = imm<<2); PCSource  out  2 (0 = ALU, 1 = ALUOut, 2 = jump, 3 = rs).
REQ-010 Ports state  out  3; instr_done  out  1 (one-cycle pulse); trap  out  1 (sticky).

Function
REQ-011 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; the state port SHALL show the current state.
REQ-012 All outputs SHALL be Moore-decoded from state and the registered opcode/funct; outputs not listed for a state SHALL be 0.
REQ-013 FETCH: mem_req=1 and IorD=0. On mem_ready=1: IRWrite=1, PCWrite=1, ALUSrcB=1, PCSource=0, then go to DECODE. Otherwise stay in FETCH.
REQ-014 DECODE: ALUSrcB=3 (branch target into ALUOut). The next state SHALL be chosen by class per REQ-015 to REQ-019.
REQ-015 R-type ALU ops (add, sub, and, or, xor, nor, slt, sll, srl) and I-type ops (addi, andi, slti, ori) SHALL go to EXEC, then WB.
REQ-015 cont. ALUOp SHALL use these codes: add 0, sub 1, and 2, or 3, xor 4, nor 5, slt 6, sll 7, srl 8, beq 9, bne 10.
REQ-015 cont. WB SHALL assert RegWrite=1; RegDst=1 for I-type.
REQ-016 lw, sw, lh, sh: EXEC (ALUOp=0, ALUSrcB=2), then MEM with mem_req=1 and IorD=1; MemWrite=1 for stores; Signextend=1 for lh/sh.
REQ-016 cont. Stores SHALL go MEM to FETCH on mem_ready. Loads SHALL go MEM to WB on mem_ready, with WB asserting MemToReg=1, RegDst=1, RegWrite=1.
REQ-017 beq/bne: EXEC with Branch=1, ALUOp 9 or 10, PCSource=1, Bne=1 for bne; then FETCH.
REQ-018 j: DECODE SHALL assert PCWrite=1 and PCSource=2, then go to FETCH. jal: additionally RegWrite=1 and Jal=1 in the same cycle.
REQ-019 jr: DECODE SHALL assert PCWrite=1, PCSource=3, Jr=1, then go to FETCH. jalr: additionally Jal=1 and RegWrite=1.
REQ-020 An undefined opcode, or an undefined funct with opcode 0, SHALL go DECODE to TRAP; trap=1.
REQ-020 cont. TRAP SHALL hold until reset, with all write enables 0.
REQ-021 instr_done SHALL pulse 1 in the final cycle of each instruction: WB, store MEM on ready, branch EXEC, or jump DECODE.
REQ-022 An 8-bit wait counter SHALL count consecutive cycles with mem_req=1 and mem_ready=0, and SHALL clear on mem_ready or on a state change.
REQ-022 cont. When the count reaches MEM_TIMEOUT, the next state SHALL be TRAP.
REQ-023 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win: the access completes with no trap.
REQ-024 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-025 Latency: R/I-type 4 cycles, load 5, store 4, branch 3, jump 2, each with zero-wait memory.

Reset
REQ-026 rst=0 at a clock edge SHALL force FETCH, clear trap and the wait counter, and drive every output to 0 in the following cycle.
REQ-026 cont. Reset SHALL abort any instruction in progress, including mid-MEM, with no write enables asserted.

Configuration
REQ-027 Macro MULTICYCLE_HALFWORD_EN defined: lh (0x21) and sh (0x29) SHALL be decoded per REQ-016.
REQ-027 cont. Macro undefined: lh and sh SHALL be illegal opcodes and route to TRAP.

Verification
REQ-028 add (op 0, funct 0x20) with zero-wait memory -> states 0,1,2,4,0; ALUOp=0 in EXEC; RegWrite=1 in WB; instr_done high in WB only.
REQ-029 lw (0x23) with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles; MemToReg=1, RegWrite=1 in WB; total 8 cycles.
REQ-030 jal (0x03) -> DECODE asserts PCWrite=1, PCSource=2, Jal=1, RegWrite=1; returns to FETCH after 2 cycles.
REQ-031 Opcode 0x3F -> TRAP (state 7) and trap=1 held for 20 cycles; rst=0 for one cycle -> FETCH and trap=0.
REQ-032 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP entered after 15 wait cycles; mem_ready on cycle 15 -> DECODE instead.
REQ-033 rst=0 asserted mid-MEM of sw -> next cycle state 0, MemWrite=0; lh (0x21) -> TRAP without MULTICYCLE_HALFWORD_EN, Signextend=1 with it.
